sched_ctrl: RTL and testbench
=============================

Name: sched_ctrl

Overview:
- Parametrised pipeline scheduler: per-stage enables, multi-cycle stall sequencing, and a prioritised interrupt/ERET redirect with a saved return address.
- Sits beside the PC/pipeline registers.
- Accepts stall requests from the hazard unit, soft traps/ERET from decode, and N external interrupt lines.
- Drives the stage enables and the PC redirect.

Parameters:
- STAGES, 6, number of pipeline enable outputs (bit0 = PC, increasing toward writeback).
- STALL_DEPTH, 3, stages [STALL_DEPTH-1:0] are frozen during a stall; must be ≤ STAGES.
- STALL_CYCLES, 1, cycles the enables are held low per stall request; must be ≥ 1.
- N_HARD_INT, 4, external interrupt lines, 1..8.
- ADDR_W, 16, PC/EPC width.
- VECTOR_BASE, 16'h0004, trap handler address.
- ERET_ID, 4'hF, soft-int id meaning "return from exception".

Ports:
- schi_clk  in  1  clock, rising edge.
- schi_rst  in  1  asynchronous reset, active-high.
- schi_pause_request  in  1  hazard stall request, level.
- schi_hard_int  in  N_HARD_INT  external interrupt lines, synchronous to schi_clk.
- schi_int  in  1  soft trap / ERET strobe, one cycle.
- schi_int_id  in  4  trap id; ERET_ID means ERET.
- schi_epc  in  ADDR_W  PC of the instruction in the trap-sampling stage.
- scho_interrupt_set_pc  out  1  one-cycle redirect strobe.
- scho_epc  out  ADDR_W  redirect target.
- scho_epc_in  out  ADDR_W  saved return address.
- scho_cause  out  4  cause of the last trap taken.
- scho_in_service  out  1  handler active (between trap and ERET).
- scho_pending  out  N_HARD_INT  latched hard-interrupt requests.
- scho_stage_en  out  STAGES  pipeline register enables.
- scho_read_from_last2  out  1  forwarding mux select during stall release.

Behaviour:
- Reset (async, high): all enables 1; set_pc=0, epc=0, epc_in=0, cause=0, in_service=0, pending=0, read_from_last2=0; stall FSM=RUN; edge-detect register=0.

Stall FSM (RUN, STALL, RELEASE), counter cnt:
- RUN with pause_request=1: scho_stage_en[STALL_DEPTH-1:0]=0 combinationally in the same cycle. Next state is RELEASE if STALL_CYCLES==1, else STALL with cnt=STALL_CYCLES-2.
- STALL: frozen stages' enables=0. cnt==0 → RELEASE, else cnt−1.
- RELEASE: all enables=1, read_from_last2=1 for exactly one cycle; pause_request is ignored; next state RUN.
- Net effect: one request freezes stages for exactly STALL_CYCLES cycles, then one release cycle.
- Stages [STAGES-1:STALL_DEPTH] are always enabled.

Hard interrupt capture:
- Rising edge per line: hard_int & ~prev.
- pending[i] is set on an edge and cleared when line i is taken. A set and a clear in the same cycle: set wins.

Trap arbitration (registered; effect visible the cycle after the sampling edge):
1. schi_int with id==ERET_ID:
   - set_pc=1, epc=epc_in, in_service=0.
   - cause unchanged; taken even if in_service=0.
2. schi_int with other id:
   - set_pc=1, epc=vector(id), epc_in=schi_epc+1, cause=id, in_service=1.
   - Taken even when in_service=1 (overwrites epc_in).
3. Else, any pending bit and in_service=0:
   - Lowest index i wins: set_pc=1, epc=vector(8+i), epc_in=schi_epc, cause=8+i, in_service=1, pending[i] cleared.
   - Pending hard interrupts wait while in_service=1 (no nesting).
4. Else set_pc=0; epc holds its last value.

Other rules:
- Any cycle that produces set_pc=1 forces the stall FSM to RUN on the same edge; a trap aborts an in-flight stall.
- Address arithmetic is modulo 2^ADDR_W: epc+1 wraps from all-ones to 0.
- Simultaneous soft int and hard edge: the soft int is taken and the hard edge stays pending.

Optional Feature:
- SCHED_VECTOR_TABLE_EN defined: vector(c)=VECTOR_BASE+(c<<2), giving a distinct handler per cause.
- Undefined: vector(c)=VECTOR_BASE for every cause; software dispatches on scho_cause.

Test Plan:
- Reset with pause_request=1 → stage_en all 1, set_pc=0. Release reset, STALL_CYCLES=1, pause high 2 cycles → en[2:0]=0 in cycle 0; cycle 1 en=6'h3F, read_from_last2=1; cycle 2 RUN, en[2:0]=0 again.
- STALL_CYCLES=3, single pause pulse → en[2:0]=0 for 3 cycles, then 1 release cycle, then RUN; en[5:3] stay 1 throughout.
- schi_int=1, id=2, epc=16'h0100 → next cycle set_pc=1, epc=16'h0004 (16'h000C with macro), epc_in=16'h0101, cause=2, in_service=1. Then id=ERET_ID → set_pc=1, epc=16'h0101, in_service=0.
- hard_int[3] and hard_int[1] rise together, epc=16'h0200 → line 1 taken (cause=9, epc_in=16'h0200), pending=4'b1000. Line 3 is taken only after ERET.
- Soft int and hard_int[0] rise in the same cycle → soft taken, pending[0]=1. During a STALL the trap forces RUN and en=all 1 next cycle.
- epc=16'hFFFF soft trap → epc_in=16'h0000. Async reset asserted mid-stall → all outputs return to reset values immediately.

Source files
------------

// File: rtl/sched_ctrl.sv
// Pipeline scheduler: per-stage enables, multi-cycle stall sequencing and a prioritised
// trap/ERET/hard-interrupt PC redirect. Define SCHED_VECTOR_TABLE_EN for per-cause vectors.
module sched_ctrl #(
    parameter int               STAGES       = 6,
    parameter int               STALL_DEPTH  = 3,
    parameter int               STALL_CYCLES = 1,
    parameter int               N_HARD_INT   = 4,
    parameter int               ADDR_W       = 16,
    parameter logic [ADDR_W-1:0] VECTOR_BASE = ADDR_W'(4),
    parameter logic [3:0]       ERET_ID      = 4'hF
) (
    input  logic                  schi_clk,
    input  logic                  schi_rst,
    input  logic                  schi_pause_request,
    input  logic [N_HARD_INT-1:0] schi_hard_int,
    input  logic                  schi_int,
    input  logic [3:0]            schi_int_id,
    input  logic [ADDR_W-1:0]     schi_epc,
    output logic                  scho_interrupt_set_pc,
    output logic [ADDR_W-1:0]     scho_epc,
    output logic [ADDR_W-1:0]     scho_epc_in,
    output logic [3:0]            scho_cause,
    output logic                  scho_in_service,
    output logic [N_HARD_INT-1:0] scho_pending,
    output logic [STAGES-1:0]     scho_stage_en,
    output logic                  scho_read_from_last2
);

    localparam int CNT_W = (STALL_CYCLES > 2) ? $clog2(STALL_CYCLES - 1) : 1;

    typedef enum logic [1:0] {ST_RUN, ST_STALL, ST_RELEASE} stall_state_t;

    stall_state_t          state, state_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic                  freeze;
    logic [N_HARD_INT-1:0] hard_prev, hard_edge, clr_mask;
    logic                  hard_hit;
    logic [2:0]            hard_idx;
    logic [3:0]            trap_cause;
    logic [ADDR_W-1:0]     vec_addr;
    logic                  take;
    logic [ADDR_W-1:0]     epc_nxt, epc_in_nxt;
    logic [3:0]            cause_nxt;
    logic                  in_service_nxt;

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        freeze    = 1'b0;
        case (state)
            ST_RUN: begin
                if (schi_pause_request) begin
                    freeze = 1'b1;
                    if (STALL_CYCLES == 1) begin
                        state_nxt = ST_RELEASE;
                    end else begin
                        state_nxt = ST_STALL;
                        cnt_nxt   = CNT_W'(STALL_CYCLES - 2);
                    end
                end
            end
            ST_STALL: begin
                freeze = 1'b1;
                if (cnt == '0) state_nxt = ST_RELEASE;
                else           cnt_nxt   = cnt - 1'b1;
            end
            default: state_nxt = ST_RUN;
        endcase
        // A redirect discards whatever stall was in flight.
        if (take) state_nxt = ST_RUN;
    end

    always_comb begin
        scho_stage_en = '1;
        if (freeze && !schi_rst) begin
            for (int i = 0; i < STALL_DEPTH; i++) scho_stage_en[i] = 1'b0;
        end
    end

    assign scho_read_from_last2 = (state == ST_RELEASE);
    assign hard_edge            = schi_hard_int & ~hard_prev;

    always_comb begin
        hard_hit = 1'b0;
        hard_idx = '0;
        for (int i = N_HARD_INT - 1; i >= 0; i--) begin
            if (scho_pending[i]) begin
                hard_hit = 1'b1;
                hard_idx = 3'(i);
            end
        end
    end

    assign trap_cause = schi_int ? schi_int_id : {1'b1, hard_idx};

`ifdef SCHED_VECTOR_TABLE_EN
    assign vec_addr = VECTOR_BASE + (ADDR_W'(trap_cause) << 2);
`else
    assign vec_addr = VECTOR_BASE;
`endif

    always_comb begin
        take           = 1'b0;
        clr_mask       = '0;
        epc_nxt        = scho_epc;
        epc_in_nxt     = scho_epc_in;
        cause_nxt      = scho_cause;
        in_service_nxt = scho_in_service;
        if (schi_int && schi_int_id == ERET_ID) begin
            take           = 1'b1;
            epc_nxt        = scho_epc_in;
            in_service_nxt = 1'b0;
        end else if (schi_int) begin
            take           = 1'b1;
            epc_nxt        = vec_addr;
            epc_in_nxt     = schi_epc + 1'b1;
            cause_nxt      = trap_cause;
            in_service_nxt = 1'b1;
        end else if (hard_hit && !scho_in_service) begin
            take           = 1'b1;
            epc_nxt        = vec_addr;
            epc_in_nxt     = schi_epc;
            cause_nxt      = trap_cause;
            in_service_nxt = 1'b1;
            clr_mask       = N_HARD_INT'(1) << hard_idx;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge schi_clk or posedge schi_rst) begin
        if (schi_rst) begin
            state                 <= ST_RUN;
            cnt                   <= '0;
            hard_prev             <= '0;
            scho_pending          <= '0;
            scho_interrupt_set_pc <= 1'b0;
            scho_epc              <= '0;
            scho_epc_in           <= '0;
            scho_cause            <= '0;
            scho_in_service       <= 1'b0;
        end else begin
            state                 <= state_nxt;
            cnt                   <= cnt_nxt;
            hard_prev             <= schi_hard_int;
            // A new edge on a line being taken this cycle re-arms it.
            scho_pending          <= (scho_pending & ~clr_mask) | hard_edge;
            scho_interrupt_set_pc <= take;
            scho_epc              <= epc_nxt;
            scho_epc_in           <= epc_in_nxt;
            scho_cause            <= cause_nxt;
            scho_in_service       <= in_service_nxt;
        end
    end

endmodule

// File: tb/tb_sched_ctrl.sv
// Scoreboard bench for sched_ctrl: two instances (STALL_CYCLES 1 and 3) share stimulus and
// are compared each cycle against a behavioural model of stalls, traps and pending lines.
module tb_sched_ctrl;

    localparam int         N    = 4;
    localparam int         AW   = 16;
    localparam logic [3:0] ERET = 4'hF;
`ifdef SCHED_VECTOR_TABLE_EN
    localparam bit VEC_TABLE = 1'b1;
`else
    localparam bit VEC_TABLE = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pause = 1'b0;
    logic [N-1:0]  hard = '0;
    logic          sint = 1'b0;
    logic [3:0]    id = '0;
    logic [AW-1:0] epc_i = '0;

    logic          a_set_pc, b_set_pc, a_insvc, b_insvc, a_rfl, b_rfl;
    logic [AW-1:0] a_epc, b_epc, a_epc_in, b_epc_in;
    logic [3:0]    a_cause, b_cause;
    logic [N-1:0]  a_pend, b_pend;
    logic [5:0]    a_en, b_en;

    always #5 clk = ~clk;

    sched_ctrl #(.STALL_CYCLES(1)) dut_a (
        .schi_clk(clk), .schi_rst(rst), .schi_pause_request(pause), .schi_hard_int(hard),
        .schi_int(sint), .schi_int_id(id), .schi_epc(epc_i),
        .scho_interrupt_set_pc(a_set_pc), .scho_epc(a_epc), .scho_epc_in(a_epc_in),
        .scho_cause(a_cause), .scho_in_service(a_insvc), .scho_pending(a_pend),
        .scho_stage_en(a_en), .scho_read_from_last2(a_rfl)
    );

    sched_ctrl #(.STALL_CYCLES(3)) dut_b (
        .schi_clk(clk), .schi_rst(rst), .schi_pause_request(pause), .schi_hard_int(hard),
        .schi_int(sint), .schi_int_id(id), .schi_epc(epc_i),
        .scho_interrupt_set_pc(b_set_pc), .scho_epc(b_epc), .scho_epc_in(b_epc_in),
        .scho_cause(b_cause), .scho_in_service(b_insvc), .scho_pending(b_pend),
        .scho_stage_en(b_en), .scho_read_from_last2(b_rfl)
    );

    typedef struct {
        logic [5:0]    en_a;
        logic          rfl_a;
        logic [5:0]    en_b;
        logic          rfl_b;
        logic          set_pc;
        logic [AW-1:0] epc;
        logic [AW-1:0] epc_in;
        logic [3:0]    cause;
        logic          insvc;
        logic [N-1:0]  pend;
    } exp_t;

    exp_t cq[$];
    int   checks   = 0;
    int   failures = 0;

    // Model state: frozen cycles still to come and a pending release cycle, per instance.
    int            k_a, k_b;
    bit            rel_a, rel_b;
    logic [N-1:0]  m_prev, m_pend;
    logic [AW-1:0] m_epc, m_epc_in;
    logic [3:0]    m_cause;
    bit            m_insvc, m_setpc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] vec(input logic [3:0] c);
        return 16'h0004 + (VEC_TABLE ? {10'b0, c, 2'b00} : 16'h0000);
    endfunction

    function automatic logic [5:0] en_of(input int k, input bit rel, input logic p);
        return (k > 0 || (!rel && p)) ? 6'h38 : 6'h3F;
    endfunction

    task automatic step_stall(input int sc, input bit trap, input logic p,
                              inout int k, inout bit rel);
        if (trap) begin
            k = 0; rel = 1'b0;
        end else if (k > 0) begin
            k = k - 1; rel = (k == 0);
        end else if (rel) begin
            rel = 1'b0;
        end else if (p) begin
            k = sc - 1; rel = (sc == 1);
        end
    endtask

    task automatic reset_model();
        k_a = 0; k_b = 0; rel_a = 1'b0; rel_b = 1'b0;
        m_prev = '0; m_pend = '0; m_epc = '0; m_epc_in = '0; m_cause = '0;
        m_insvc = 1'b0; m_setpc = 1'b0;
    endtask

    // One clock: drive inputs after the edge, queue the expected outputs for this cycle,
    // then advance the model across the coming edge.
    task automatic cycle(input bit r, input logic p, input logic [N-1:0] h, input logic s,
                         input logic [3:0] i, input logic [AW-1:0] e);
        exp_t x;
        bit   take;
        int   w;
        @(posedge clk);
        #1;
        rst = r; pause = p; hard = h; sint = s; id = i; epc_i = e;
        if (r) reset_model();
        x.en_a   = r ? 6'h3F : en_of(k_a, rel_a, p);
        x.rfl_a  = (k_a == 0) && rel_a;
        x.en_b   = r ? 6'h3F : en_of(k_b, rel_b, p);
        x.rfl_b  = (k_b == 0) && rel_b;
        x.set_pc = m_setpc;
        x.epc    = m_epc;
        x.epc_in = m_epc_in;
        x.cause  = m_cause;
        x.insvc  = m_insvc;
        x.pend   = m_pend;
        cq.push_back(x);
        if (!r) begin
            take = 1'b0;
            w    = -1;
            for (int j = N - 1; j >= 0; j--) if (m_pend[j]) w = j;
            if (s && i == ERET) begin
                take = 1'b1; m_epc = m_epc_in; m_insvc = 1'b0;
            end else if (s) begin
                take = 1'b1; m_epc = vec(i); m_epc_in = e + 16'd1; m_cause = i; m_insvc = 1'b1;
            end else if (!m_insvc && w >= 0) begin
                take = 1'b1; m_cause = 4'(8 + w); m_epc = vec(m_cause); m_epc_in = e;
                m_insvc = 1'b1; m_pend[w] = 1'b0;
            end
            m_pend  = m_pend | (h & ~m_prev);
            m_prev  = h;
            m_setpc = take;
            step_stall(1, take, p, k_a, rel_a);
            step_stall(3, take, p, k_b, rel_b);
        end
    endtask

    task automatic idle(input int n, input logic [N-1:0] h);
        for (int c = 0; c < n; c++) cycle(1'b0, 1'b0, h, 1'b0, 4'h0, 16'h0);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            if (cq.size() > 0) begin
                x = cq.pop_front();
                check("stage_en_a", 32'(a_en), 32'(x.en_a));
                check("last2_a", 32'(a_rfl), 32'(x.rfl_a));
                check("stage_en_b", 32'(b_en), 32'(x.en_b));
                check("last2_b", 32'(b_rfl), 32'(x.rfl_b));
                check("set_pc_a", 32'(a_set_pc), 32'(x.set_pc));
                check("set_pc_b", 32'(b_set_pc), 32'(x.set_pc));
                check("in_service_a", 32'(a_insvc), 32'(x.insvc));
                check("in_service_b", 32'(b_insvc), 32'(x.insvc));
                check("pending_a", 32'(a_pend), 32'(x.pend));
                check("pending_b", 32'(b_pend), 32'(x.pend));
                check("epc_a", 32'(a_epc), 32'(x.epc));
                check("epc_b", 32'(b_epc), 32'(x.epc));
                check("epc_in_a", 32'(a_epc_in), 32'(x.epc_in));
                check("epc_in_b", 32'(b_epc_in), 32'(x.epc_in));
                check("cause_a", 32'(a_cause), 32'(x.cause));
                check("cause_b", 32'(b_cause), 32'(x.cause));
            end
        end
    end

    initial begin : stimulus
        logic [N-1:0] h;
        reset_model();
        // Reset held with a pause request: enables must stay high.
        repeat (3) cycle(1'b1, 1'b1, '0, 1'b0, 4'h0, 16'h0);
        cycle(1'b0, 1'b1, '0, 1'b0, 4'h0, 16'h0);
        cycle(1'b0, 1'b1, '0, 1'b0, 4'h0, 16'h0);
        cycle(1'b0, 1'b1, '0, 1'b0, 4'h0, 16'h0);
        idle(6, '0);
        cycle(1'b0, 1'b1, '0, 1'b0, 4'h0, 16'h0);
        idle(6, '0);
        // Soft trap then ERET.
        cycle(1'b0, 1'b0, '0, 1'b1, 4'h2, 16'h0100);
        idle(2, '0);
        cycle(1'b0, 1'b0, '0, 1'b1, ERET, 16'h0);
        idle(2, '0);
        // Two lines rise together; lowest wins, the other waits for ERET.
        repeat (3) cycle(1'b0, 1'b0, 4'b1010, 1'b0, 4'h0, 16'h0200);
        idle(3, '0);
        cycle(1'b0, 1'b0, '0, 1'b1, ERET, 16'h0);
        idle(3, '0);
        cycle(1'b0, 1'b0, '0, 1'b1, ERET, 16'h0);
        idle(2, '0);
        // Soft trap beats a same-cycle hard edge; a trap aborts a stall.
        cycle(1'b0, 1'b0, 4'b0001, 1'b1, 4'h5, 16'h0300);
        cycle(1'b0, 1'b0, '0, 1'b0, 4'h0, 16'h0);
        cycle(1'b0, 1'b1, '0, 1'b0, 4'h0, 16'h0);
        cycle(1'b0, 1'b0, '0, 1'b1, 4'h3, 16'h0400);
        idle(3, '0);
        cycle(1'b0, 1'b0, '0, 1'b1, ERET, 16'h0);
        idle(3, '0);
        cycle(1'b0, 1'b0, '0, 1'b1, ERET, 16'h0);
        idle(2, '0);
        // Return address wraps.
        cycle(1'b0, 1'b0, '0, 1'b1, 4'h1, 16'hFFFF);
        idle(2, '0);
        cycle(1'b0, 1'b0, '0, 1'b1, ERET, 16'h0);
        idle(2, '0);
        // Asynchronous reset in the middle of a stall.
        cycle(1'b0, 1'b1, '0, 1'b0, 4'h0, 16'h0);
        cycle(1'b0, 1'b0, '0, 1'b0, 4'h0, 16'h0);
        cycle(1'b1, 1'b1, '0, 1'b0, 4'h0, 16'h0);
        cycle(1'b1, 1'b0, '0, 1'b0, 4'h0, 16'h0);
        idle(2, '0);
        // Randomized traffic.
        h = '0;
        for (int c = 0; c < 3000; c++) begin
            logic [3:0] rid;
            if ($urandom_range(0, 3) == 0) h = h ^ N'($urandom_range(0, 15) & $urandom_range(0, 15));
            rid = ($urandom_range(0, 2) == 0) ? ERET : 4'($urandom_range(0, 14));
            cycle($urandom_range(0, 599) == 0, $urandom_range(0, 9) < 3, h,
                  $urandom_range(0, 14) == 0, rid, 16'($urandom));
        end
        idle(2, '0);
        @(negedge clk);
        #1;
        check("queue_drained", 32'(cq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
